// File: rtl/collision_scan_arbiter_if.sv
// Rectangle payload type and the requester/obstacle-table bundle for collision_scan_arbiter.
package collision_scan_arbiter_pkg;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } point_t;

  // Axis-aligned rectangle given by its center and half-extents.
  typedef struct packed {
    point_t center;
    point_t radius;
  } rect_t;

endpackage

interface collision_scan_arbiter_if
  import collision_scan_arbiter_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 4
);

  logic [N-1:0]  req;
  rect_t [N-1:0] queryArea;
  logic [IW-1:0] obsIdx;
  rect_t         obsArea;
  logic          obsExists;
  logic [N-1:0]  done;
  logic          hit;
  logic [IW-1:0] hitIdx;
  logic          busy;

  // Arbiter side.
  modport slave (
    input  req, queryArea, obsArea, obsExists,
    output obsIdx, done, hit, hitIdx, busy
  );

  // Requesters plus obstacle table side.
  modport master (
    output req, queryArea, obsArea, obsExists,
    input  obsIdx, done, hit, hitIdx, busy
  );

endinterface

// File: rtl/collision_scan_arbiter.sv
// Round-robin shared rectangle-overlap scanner over an obstacle table.
module collision_scan_arbiter
  import collision_scan_arbiter_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned M          = 16,
  parameter int unsigned EARLY_EXIT = 1,
  parameter int unsigned IW         = (M > 1) ? $clog2(M) : 1
) (
  input logic                 sysClk,
  input logic                 reset_l,
  collision_scan_arbiter_if.slave bus
);

  localparam int unsigned OW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] last_q, last_d;
  logic [OW-1:0] owner_q, owner_d;
  rect_t         query_q, query_d;
  logic          found_q, found_d;
  logic [IW-1:0] found_idx_q, found_idx_d;
  logic [IW-1:0] obs_idx_q, obs_idx_d;
  logic [N-1:0]  done_q, done_d;
  logic          hit_q, hit_d;
  logic [IW-1:0] hit_idx_q, hit_idx_d;
  logic          busy_q, busy_d;

  logic          grant_valid;
  logic [OW-1:0] grant_idx;
  logic          entry_hit;
  logic          result_found;
  logic [IW-1:0] result_idx;

  // Inclusive 1-D overlap: |a-b| <= ra+rb, magnitude taken larger-minus-smaller.
  function automatic logic axis_overlap(input logic [7:0] qc, input logic [7:0] qr,
                                        input logic [7:0] oc, input logic [7:0] orad);
    logic [7:0] diff;
    logic [8:0] sum;
    diff = (qc >= oc) ? (qc - oc) : (oc - qc);
    sum  = {1'b0, qr} + {1'b0, orad};
    return ({1'b0, diff} <= sum);
  endfunction

  // Shared comparator: latched query against the table entry currently addressed.
  always_comb begin
    entry_hit = axis_overlap(query_q.center.x, query_q.radius.x,
                             bus.obsArea.center.x, bus.obsArea.radius.x) &&
                axis_overlap(query_q.center.y, query_q.radius.y,
                             bus.obsArea.center.y, bus.obsArea.radius.y) &&
                bus.obsExists;
  end

  // Round-robin pick: first requester after the last one served, wrapping at N.
  always_comb begin
    logic [OW-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = OW'((32'(last_q) + i) % N);
      if (!grant_valid && bus.req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Result including a hit seen at the current index this cycle.
  always_comb begin
    result_found = found_q || entry_hit;
    result_idx   = found_q ? found_idx_q : obs_idx_q;
  end

  // State and registered outputs.
  always_ff @(posedge sysClk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= IDLE;
      last_q      <= OW'(N - 1);
      owner_q     <= '0;
      query_q     <= '0;
      found_q     <= 1'b0;
      found_idx_q <= '0;
      obs_idx_q   <= '0;
      done_q      <= '0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      query_q     <= query_d;
      found_q     <= found_d;
      found_idx_q <= found_idx_d;
      obs_idx_q   <= obs_idx_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
      hit_idx_q   <= hit_idx_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output logic; result outputs are zero unless reporting.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    query_d     = query_q;
    found_d     = found_q;
    found_idx_d = found_idx_q;
    obs_idx_d   = obs_idx_q;
    done_d      = '0;
    hit_d       = 1'b0;
    hit_idx_d   = '0;

    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          query_d     = bus.queryArea[grant_idx];
          owner_d     = grant_idx;
          obs_idx_d   = '0;
          found_d     = 1'b0;
          found_idx_d = '0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (!bus.req[owner_q]) begin
          // Requester withdrew: discard the scan silently.
          state_d = IDLE;
          last_d  = owner_q;
        end else begin
          if (entry_hit && !found_q) begin
            found_d     = 1'b1;
            found_idx_d = obs_idx_q;
          end
          if ((entry_hit && (EARLY_EXIT != 0)) || (obs_idx_q == IW'(M - 1))) begin
            state_d         = REPORT;
            done_d[owner_q] = 1'b1;
            hit_d           = result_found;
            hit_idx_d       = result_found ? result_idx : '0;
          end else begin
            obs_idx_d = IW'(obs_idx_q + 1'b1);
          end
        end
      end
      REPORT: begin
        state_d   = IDLE;
        last_d    = owner_q;
        obs_idx_d = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.obsIdx = obs_idx_q;
  assign bus.done   = done_q;
  assign bus.hit    = hit_q;
  assign bus.hitIdx = hit_idx_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_collision_scan_arbiter.sv
// Self-checking bench: two arbiters (early exit on/off) sharing one obstacle table model.
module tb_collision_scan_arbiter;
  import collision_scan_arbiter_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned M  = 8;
  localparam int unsigned IW = 3;

  logic sysClk  = 1'b0;
  logic reset_l = 1'b0;
  always #5 sysClk = ~sysClk;

  collision_scan_arbiter_if #(.N(N), .IW(IW)) bus1 ();
  collision_scan_arbiter_if #(.N(N), .IW(IW)) bus0 ();

  collision_scan_arbiter #(.N(N), .M(M), .EARLY_EXIT(1), .IW(IW)) dut1 (
    .sysClk(sysClk), .reset_l(reset_l), .bus(bus1.slave));
  collision_scan_arbiter #(.N(N), .M(M), .EARLY_EXIT(0), .IW(IW)) dut0 (
    .sysClk(sysClk), .reset_l(reset_l), .bus(bus0.slave));

  logic [N-1:0]  req1, req0;
  rect_t [N-1:0] qa;
  rect_t         obs_tab [M];
  logic          obs_ex  [M];

  assign bus1.req       = req1;
  assign bus1.queryArea = qa;
  assign bus1.obsArea   = obs_tab[bus1.obsIdx];
  assign bus1.obsExists = obs_ex[bus1.obsIdx];
  assign bus0.req       = req0;
  assign bus0.queryArea = qa;
  assign bus0.obsArea   = obs_tab[bus0.obsIdx];
  assign bus0.obsExists = obs_ex[bus0.obsIdx];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic rect_t mk(input int cx, input int cy, input int rx, input int ry);
    rect_t t;
    t.center.x = 8'(cx);
    t.center.y = 8'(cy);
    t.radius.x = 8'(rx);
    t.radius.y = 8'(ry);
    return t;
  endfunction

  // Reference geometry in plain signed integers.
  function automatic bit ref_overlap(input rect_t q, input rect_t o);
    int dx, dy;
    dx = int'(q.center.x) - int'(o.center.x);
    dy = int'(q.center.y) - int'(o.center.y);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return (dx <= int'(q.radius.x) + int'(o.radius.x)) &&
           (dy <= int'(q.radius.y) + int'(o.radius.y));
  endfunction

  // Lowest existing overlapping entry, or none.
  task automatic ref_scan(input rect_t q, output bit h, output int idx);
    h = 1'b0;
    idx = 0;
    for (int i = 0; i < int'(M); i++) begin
      if (!h && obs_ex[i] && ref_overlap(q, obs_tab[i])) begin
        h = 1'b1;
        idx = i;
      end
    end
  endtask

  task automatic tick();
    @(posedge sysClk);
    @(negedge sysClk);
  endtask

  task automatic fill_far();
    for (int i = 0; i < int'(M); i++) begin
      obs_tab[i] = mk(10, 10, 1, 1);
      obs_ex[i]  = 1'b1;
    end
  endtask

  // One transaction on both DUTs from the same requester; checks against the reference.
  task automatic run_txn(input int r, input rect_t q,
                         output bit h1, output int i1, output int l1,
                         output int l0, output int i0);
    bit eh;
    int ei;
    ref_scan(q, eh, ei);
    qa[r] = q;
    req1[r] = 1'b1;
    req0[r] = 1'b1;
    l1 = -1; l0 = -1; h1 = 1'b0; i1 = 0; i0 = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (l1 < 0) begin
        check("busy_ee1", bus1.busy, 1);
        if (bus1.done != '0) begin
          l1 = c;
          check("done_ee1", bus1.done, 32'(1) << r);
          check("hit_ee1", bus1.hit, eh);
          check("hitidx_ee1", bus1.hitIdx, ei);
          h1 = bus1.hit;
          i1 = int'(bus1.hitIdx);
          req1[r] = 1'b0;
        end else begin
          check("quiet_ee1", {bus1.hit, bus1.hitIdx}, 0);
        end
      end else begin
        check("idle_ee1", bus1.busy, 0);
      end
      if (l0 < 0) begin
        check("busy_ee0", bus0.busy, 1);
        if (bus0.done != '0) begin
          l0 = c;
          check("done_ee0", bus0.done, 32'(1) << r);
          check("hit_ee0", bus0.hit, eh);
          check("hitidx_ee0", bus0.hitIdx, ei);
          i0 = int'(bus0.hitIdx);
          req0[r] = 1'b0;
        end else begin
          check("quiet_ee0", {bus0.hit, bus0.hitIdx}, 0);
        end
      end
      if (l1 > 0 && l0 > 0) break;
    end
    check("latency_ee1", l1, eh ? ei + 2 : int'(M) + 1);
    check("latency_ee0", l0, int'(M) + 1);
    req1 = '0;
    req0 = '0;
    tick();
  endtask

  initial begin
    bit h1;
    int i1, l1, l0, i0, n, k;
    logic [N-1:0] prev_done;
    int exp_rr [6];
    rect_t q0;

    exp_rr = '{0, 1, 3, 0, 1, 3};
    q0 = mk(100, 100, 8, 8);
    req1 = '0;
    req0 = '0;
    qa = '0;
    fill_far();
    repeat (3) tick();
    reset_l = 1'b1;
    tick();
    check("reset_done", bus1.done, 0);
    check("reset_busy", bus1.busy, 0);
    check("reset_obsidx", bus1.obsIdx, 0);
    check("reset_hit", {bus1.hit, bus1.hitIdx}, 0);

    // Round robin with requesters 0,1,3 held.
    for (int i = 0; i < int'(N); i++) qa[i] = q0;
    req1 = 4'b1011;
    n = 0;
    prev_done = '0;
    for (int c = 0; c < 150 && n < 6; c++) begin
      tick();
      if (bus1.done != '0) begin
        check("rr_onehot", $onehot(bus1.done), 1);
        check("rr_gap", prev_done, 0);
        check("rr_order", bus1.done, 32'(1) << exp_rr[n]);
        n++;
        if (n == 6) req1 = '0;
      end
      prev_done = bus1.done;
    end
    check("rr_count", n, 6);
    tick();
    tick();

    // No overlap anywhere.
    fill_far();
    run_txn(0, q0, h1, i1, l1, l0, i0);
    check("tp_miss_lat", l1, 9);
    check("tp_miss_hit", h1, 0);
    check("tp_miss_lat_ee0", l0, 9);

    // Entries 5 and 6 overlap; lowest index wins.
    obs_tab[5] = mk(110, 100, 2, 2);
    obs_tab[6] = mk(105, 100, 1, 1);
    run_txn(0, q0, h1, i1, l1, l0, i0);
    check("tp_hit5_lat", l1, 7);
    check("tp_hit5_hit", h1, 1);
    check("tp_hit5_idx", i1, 5);
    check("tp_hit5_lat_ee0", l0, 9);
    check("tp_hit5_idx_ee0", i0, 5);

    // Edge touching and just apart.
    fill_far();
    obs_tab[0] = mk(116, 100, 8, 8);
    run_txn(1, q0, h1, i1, l1, l0, i0);
    check("edge_touch_hit", h1, 1);
    check("edge_touch_lat", l1, 2);
    obs_tab[0] = mk(117, 100, 8, 8);
    run_txn(2, q0, h1, i1, l1, l0, i0);
    check("edge_apart_hit", h1, 0);
    obs_tab[0] = mk(84, 100, 8, 8);
    run_txn(3, q0, h1, i1, l1, l0, i0);
    check("edge_left_hit", h1, 1);

    // Overlapping but nonexistent entry.
    fill_far();
    obs_tab[2] = mk(100, 100, 3, 3);
    obs_ex[2]  = 1'b0;
    run_txn(1, q0, h1, i1, l1, l0, i0);
    check("noexist_hit", h1, 0);

    // Randomized tables and queries.
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < int'(M); i++) begin
        obs_tab[i] = mk(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                        int'($urandom_range(0, 20)), int'($urandom_range(0, 20)));
        obs_ex[i]  = ($urandom_range(0, 3) != 0);
      end
      run_txn(int'($urandom_range(0, N - 1)),
              mk(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 60)), int'($urandom_range(0, 60))),
              h1, i1, l1, l0, i0);
    end

    // Withdraw mid-scan.
    fill_far();
    qa[2] = q0;
    req1[2] = 1'b1;
    repeat (3) tick();
    check("abort_busy_before", bus1.busy, 1);
    req1[2] = 1'b0;
    tick();
    check("abort_busy_after", bus1.busy, 0);
    check("abort_done", bus1.done, 0);
    for (int c = 0; c < 12; c++) begin
      tick();
      check("abort_no_done", bus1.done, 0);
    end

    // Asynchronous reset mid-scan, then priority returns to requester 0.
    qa[1] = q0;
    req1[1] = 1'b1;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus1.obsIdx == 3'd3) break;
    end
    check("rst_reach_idx3", bus1.obsIdx, 3);
    #2 reset_l = 1'b0;
    #1;
    check("arst_done", bus1.done, 0);
    check("arst_hit", {bus1.hit, bus1.hitIdx}, 0);
    check("arst_obsidx", bus1.obsIdx, 0);
    check("arst_busy", bus1.busy, 0);
    @(negedge sysClk);
    reset_l = 1'b1;
    req1 = 4'b1111;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus1.done != '0) begin
        k = int'(bus1.done);
        break;
      end
    end
    check("arst_first_grant", k, 1);
    req1 = '0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
